// File: rtl/zone_stat_gen.sv
// Per-zone backlight statistics: crops the raster into a zone grid, accumulates
// max/sum per zone and emits one backlight value per zone in raster zone order.
module zone_stat_gen #(
  parameter int DW       = 8,
  parameter int ZONE_W   = 53,
  parameter int ZONE_H   = 53,
  parameter int ZONES_X  = 24,
  parameter int ZONES_Y  = 15,
  parameter int MARGIN_L = 4,
  parameter int MARGIN_T = 2
) (
  input  logic                               i_pix_clk,
  input  logic                               rst_n,
  input  logic                               data_de,
  input  logic [10:0]                        pix_x,
  input  logic [10:0]                        pix_y,
  input  logic [DW-1:0]                      data_gray,
  input  logic                               r_Vsync_0,
  input  logic [1:0]                         mode,
  input  logic [DW-1:0]                      blend_thr,
  output logic [$clog2(ZONES_X*ZONES_Y)-1:0] o_zone_idx,
  output logic [DW-1:0]                      o_zone_val,
  output logic                               o_zone_valid,
  output logic                               o_frame_done
);
  localparam int NZ      = ZONES_X * ZONES_Y;
  localparam int IW      = $clog2(NZ);
  localparam int NPIX    = ZONE_W * ZONE_H;
  localparam int SW      = DW + $clog2(NPIX);
  localparam int RW      = 25;
  localparam int RECIP_I = (16777216 + NPIX / 2) / NPIX;
  localparam logic [RW-1:0] RECIP = RW'(RECIP_I);
  localparam int XW  = $clog2(ZONE_W);
  localparam int YW  = (ZONE_H  > 1) ? $clog2(ZONE_H)  : 1;
  localparam int ZXW = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
  localparam int ZYW = (ZONES_Y > 1) ? $clog2(ZONES_Y) : 1;
  localparam logic [11:0] X_LO = 12'(MARGIN_L);
  localparam logic [11:0] X_HI = 12'(MARGIN_L + ZONES_X * ZONE_W);
  localparam logic [11:0] Y_LO = 12'(MARGIN_T);
  localparam logic [11:0] Y_HI = 12'(MARGIN_T + ZONES_Y * ZONE_H);

  // Mean by reciprocal multiply; a rounded-up reciprocal can overshoot full scale.
  function automatic logic [DW-1:0] mean_sat(input logic [SW-1:0] s);
    logic [SW+RW-1:0] prod;
    logic [SW:0]      q;
    prod = (SW+RW)'(s) * (SW+RW)'(RECIP);
    q    = (SW+1)'(prod >> 24);
    return (q > (SW+1)'(2**DW - 1)) ? {DW{1'b1}} : q[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] blend(input logic [1:0] m, input logic [DW-1:0] mx,
                                          input logic [DW-1:0] mn, input logic [DW-1:0] thr);
    logic signed [DW+1:0] diff;
    logic [DW+1:0]        wsum;
    logic [DW-1:0]        r;
    diff = $signed({2'b00, mx}) - $signed({2'b00, mn});
    wsum = '0;
    case (m)
      2'd0: r = mx;
      2'd1: r = mn;
      2'd2: begin
        wsum = {2'b00, mx} + {2'b00, mn};
        r    = (diff > $signed({2'b00, thr})) ? DW'(wsum >> 1) : mx;
      end
      default: begin
        wsum = {1'b0, mx, 1'b0} + {2'b00, mx} + {2'b00, mn};
        r    = DW'(wsum >> 2);
      end
    endcase
    return r;
  endfunction

  logic [XW-1:0]      ix;
  logic [YW-1:0]      iy;
  logic [ZXW-1:0]     zx;
  logic [ZYW-1:0]     zy;
  logic [DW-1:0]      bank_max [ZONES_X];
  logic [SW-1:0]      bank_sum [ZONES_X];
  logic [ZONES_X-1:0] bank_vld;
  logic               in_win, acc, close, first;
  logic [DW-1:0]      nxt_max;
  logic [SW-1:0]      nxt_sum;
  logic               vld_p1;
  logic [IW-1:0]      idx_p1;
  logic [DW-1:0]      max_p1, mean_p1;

  assign in_win = ({1'b0, pix_x} >= X_LO) && ({1'b0, pix_x} < X_HI) &&
                  ({1'b0, pix_y} >= Y_LO) && ({1'b0, pix_y} < Y_HI);
  assign acc    = data_de && in_win && !r_Vsync_0;
  assign close  = acc && (ix == XW'(ZONE_W - 1)) && (iy == YW'(ZONE_H - 1));
  assign first  = ((ix == '0) && (iy == '0)) || !bank_vld[zx];

  always_comb begin
    nxt_max = data_gray;
    nxt_sum = SW'(data_gray);
    if (!first) begin
      nxt_max = (data_gray > bank_max[zx]) ? data_gray : bank_max[zx];
      nxt_sum = bank_sum[zx] + SW'(data_gray);
    end
  end

  // Accumulate: zone counters and line-of-zones bank
  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      ix       <= '0;
      iy       <= '0;
      zx       <= '0;
      zy       <= '0;
      bank_vld <= '0;
      for (int i = 0; i < ZONES_X; i++) begin
        bank_max[i] <= '0;
        bank_sum[i] <= '0;
      end
    end else if (r_Vsync_0) begin
      ix       <= '0;
      iy       <= '0;
      zx       <= '0;
      zy       <= '0;
      bank_vld <= '0;
    end else if (acc) begin
      bank_max[zx] <= nxt_max;
      bank_sum[zx] <= nxt_sum;
      bank_vld[zx] <= 1'b1;
      if (ix == XW'(ZONE_W - 1)) begin
        ix <= '0;
        if (zx == ZXW'(ZONES_X - 1)) begin
          zx <= '0;
          if (iy == YW'(ZONE_H - 1)) begin
            iy <= '0;
            zy <= (zy == ZYW'(ZONES_Y - 1)) ? '0 : zy + ZYW'(1);
          end else begin
            iy <= iy + YW'(1);
          end
        end else begin
          zx <= zx + ZXW'(1);
        end
      end else begin
        ix <= ix + XW'(1);
      end
    end
  end

  // Stage 1: closing zone's final max and saturated mean
  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      idx_p1  <= '0;
      max_p1  <= '0;
      mean_p1 <= '0;
    end else begin
      vld_p1 <= close;
      if (close) begin
        idx_p1  <= IW'(int'(zy) * ZONES_X + int'(zx));
        max_p1  <= nxt_max;
        mean_p1 <= mean_sat(nxt_sum);
      end
    end
  end

  // Stage 2: mode select, outputs held between strobes
  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_zone_valid <= 1'b0;
      o_frame_done <= 1'b0;
      o_zone_idx   <= '0;
      o_zone_val   <= '0;
    end else begin
      o_zone_valid <= vld_p1;
      o_frame_done <= o_zone_valid && (o_zone_idx == IW'(NZ - 1));
      if (vld_p1) begin
        o_zone_idx <= idx_p1;
        o_zone_val <= blend(mode, max_p1, mean_p1, blend_thr);
      end
    end
  end
endmodule
